int_sched: RTL
==============

INT_SCHED -- requirements
Module: int_sched

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst; polarity and synchronicity are fixed.
REQ-002 The ports SHALL be (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- dev_irq  in  6  device interrupt lines, level, edge-captured
- dev_ack  out  6  one-cycle end-of-interrupt pulse to the serviced device
- hwint  out  6  one-hot request to CP0 HWInt[7:2]
- int_taken  in  1  CPU entered handler; same pulse as CP0 EXLSet
- int_done  in  1  handler exit (eret); same pulse as CP0 EXLClr
- bus_we  in  1  register write strobe
- bus_addr  in  2  register select
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, combinational from bus_addr

Function
REQ-003 Register map SHALL be:
- 0 MASK[5:0]: read/write.
- 1 PEND[5:0]: read; write-1-to-clear.
- 2 CUR: {valid[31], id[2:0]}; read-only.
- 3 COUNT[15:0]: read; any write clears it.
- Unused bits SHALL read 0; writes to read-only fields SHALL be ignored.
REQ-004 dev_irq SHALL be registered once into irq_q each cycle.
REQ-005 PEND[i] SHALL set on the cycle after a rising edge, i.e. dev_irq[i]=1 with irq_q[i]=0.
REQ-006 Held-high levels SHALL NOT re-set PEND.
REQ-007 FSM states SHALL be IDLE, REQ, SERVICE and EOI.
REQ-008 IDLE -> REQ: taken when (PEND & MASK) is nonzero; CUR.id SHALL latch the lowest set index (bit 0 is highest priority).
REQ-009 hwint SHALL equal onehot(CUR.id) only while in REQ, and 0 in all other states.
REQ-010 hwint SHALL be a register output, asserted the cycle after the IDLE -> REQ decision.
REQ-011 REQ -> SERVICE on int_taken=1, with these updates on that edge:
- PEND[CUR.id] clears.
- CUR.valid sets.
- COUNT increments, saturating at 16'hFFFF.
REQ-012 REQ -> IDLE (withdraw, no COUNT change) when MASK[CUR.id] reads 0, including when a bus write clears it.
REQ-013 If a withdraw and int_taken occur in the same cycle, int_taken SHALL win.
REQ-014 SERVICE -> EOI on int_done=1.
REQ-015 Higher-priority PEND bits arriving during SERVICE SHALL wait; there is no nesting.
REQ-016 EOI SHALL:
- pulse dev_ack[CUR.id] for exactly one cycle;
- clear CUR.valid;
- return to IDLE unconditionally.
REQ-017 The minimum spacing between two serviced interrupts SHALL be IDLE -> REQ -> SERVICE -> EOI -> IDLE, i.e. four cycles plus the CPU wait.
REQ-018 int_taken outside REQ and int_done outside SERVICE SHALL be ignored.
REQ-019 When a new edge-set and a clear (bus W1C or REQ -> SERVICE) hit the same PEND bit in the same cycle, set SHALL win.
REQ-020 A MASK write SHALL take effect for the arbitration decision in the following cycle.
REQ-021 dev_ack and hwint SHALL never be nonzero in the same cycle.
REQ-022 Each SHALL carry at most one bit set.

Reset
REQ-023 While rst=0, the block SHALL hold:
- state=IDLE;
- MASK=6'b000001;
- PEND, irq_q, CUR and COUNT at 0;
- hwint and dev_ack at 0.
REQ-024 Reset SHALL take effect immediately (asynchronously), including mid-REQ or mid-SERVICE, with no dev_ack pulse.
REQ-025 Operation SHALL resume on the first rising clk edge after rst deasserts.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Single service: after reset, raise dev_irq[0] -> PEND=000001, hwint=000001 two cycles later; pulse int_taken -> hwint=0, CUR=0x80000000, COUNT=1; pulse int_done -> dev_ack=000001 for one cycle, then IDLE.
- Priority: MASK=6'h3F, raise dev_irq[3] and dev_irq[1] in the same cycle -> hwint=000010; after service completes -> hwint=001000.
- Masked/withdraw: MASK=6'h3F, edge on bit 2 reaches REQ, then write MASK=0 -> hwint=0 next cycle, PEND=000100 retained, COUNT unchanged.
- Same-cycle collision: edge on dev_irq[4] in the cycle of a W1C write of 0x10 to PEND -> PEND[4]=1.
- Saturation/ignore: COUNT preloaded to 0xFFFF by 65535 services (or force) -> COUNT stays 0xFFFF; stray int_done in IDLE -> no dev_ack.
- Async reset: assert rst=0 mid-SERVICE, between clock edges -> all outputs 0 immediately, MASK=000001, no dev_ack pulse after release.

Source files
------------

// File: rtl/int_sched.sv
// Six-line edge-captured interrupt scheduler with fixed priority (bit 0
// highest), one interrupt in flight at a time and a small bus register map.
module int_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  dev_irq,
   output logic [5:0]  dev_ack,
   output logic [5:0]  hwint,
   input  logic        int_taken,
   input  logic        int_done,
   input  logic        bus_we,
   input  logic [1:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      SERVICE,
      EOI
   } state_t;

   state_t      state;
   logic [5:0]  irq_q;
   logic [5:0]  mask;
   logic [5:0]  pend;
   logic [5:0]  pm;
   logic [5:0]  rise;
   logic [5:0]  w1c;
   logic [5:0]  take_clr;
   logic [5:0]  cur_oh;
   logic [5:0]  win_oh;
   logic [2:0]  cur_id;
   logic [2:0]  win_id;
   logic        cur_valid;
   logic [15:0] count;
   logic        wr_mask;
   logic        wr_pend;
   logic        wr_count;
   logic        take;
   logic        unused_wdata;

   function automatic logic [5:0] onehot(input logic [2:0] id);
      logic [5:0] v;
      for (int i = 0; i < 6; i++) begin
         v[i] = (id == i[2:0]);
      end
      return v;
   endfunction

   assign wr_mask  = bus_we && (bus_addr == 2'd0);
   assign wr_pend  = bus_we && (bus_addr == 2'd1);
   assign wr_count = bus_we && (bus_addr == 2'd3);

   assign unused_wdata = ^bus_wdata[31:6];

   assign rise     = dev_irq & ~irq_q;
   assign pm       = pend & mask;
   assign w1c      = wr_pend ? bus_wdata[5:0] : 6'd0;
   assign cur_oh   = onehot(cur_id);
   assign win_oh   = onehot(win_id);
   assign take     = (state == REQ) && int_taken;
   assign take_clr = take ? cur_oh : 6'd0;

   // Scan downward so the lowest pending index is the one that sticks.
   always_comb begin
      win_id = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (pm[i]) win_id = i[2:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irq_q <= 6'd0;
         mask  <= 6'b000001;
         pend  <= 6'd0;
      end else begin
         irq_q <= dev_irq;
         if (wr_mask) mask <= bus_wdata[5:0];
         pend <= (pend & ~w1c & ~take_clr) | rise;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cur_id    <= 3'd0;
         cur_valid <= 1'b0;
         count     <= 16'd0;
         hwint     <= 6'd0;
         dev_ack   <= 6'd0;
      end else begin
         dev_ack <= 6'd0;
         case (state)
            IDLE: begin
               if (|pm) begin
                  state  <= REQ;
                  cur_id <= win_id;
                  hwint  <= win_oh;
               end
            end
            REQ: begin
               if (int_taken) begin
                  state     <= SERVICE;
                  cur_valid <= 1'b1;
                  hwint     <= 6'd0;
                  if (count != 16'hFFFF) count <= count + 16'd1;
               end else if (~|(mask & cur_oh)) begin
                  state <= IDLE;
                  hwint <= 6'd0;
               end
            end
            SERVICE: begin
               if (int_done) begin
                  state   <= EOI;
                  dev_ack <= cur_oh;
               end
            end
            EOI: begin
               state     <= IDLE;
               cur_valid <= 1'b0;
            end
            default: begin
               state <= IDLE;
               hwint <= 6'd0;
            end
         endcase
         // A bus clear overrides a same-cycle increment.
         if (wr_count) count <= 16'd0;
      end
   end

   always_comb begin
      bus_rdata = 32'd0;
      case (bus_addr)
         2'd0: bus_rdata = {26'd0, mask};
         2'd1: bus_rdata = {26'd0, pend};
         2'd2: bus_rdata = {cur_valid, 28'd0, cur_id};
         2'd3: bus_rdata = {16'd0, count};
         default: bus_rdata = 32'd0;
      endcase
   end

endmodule
